// File: rtl/acc_pkg.sv
// Shared types for the acc-demo trim path controller.
// State encodings and trim time width.
package acc_pkg;

  localparam int TRIM_TIME_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic scan_on(state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/acc_trim_cfg_ctrl_if.sv
// Host/trim-block signal bundle for acc_trim_cfg_ctrl.
// master drives the requests, slave is the controller.
interface acc_trim_cfg_ctrl_if
  import acc_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic                   cfg_wr_i;
  logic [TRIM_TIME_W-1:0] cfg_pose_i;
  logic [TRIM_TIME_W-1:0] cfg_nege_i;
  logic                   scan_start_i;
  logic                   scan_stop_i;
  logic                   acc_demo_flag_i;
  logic                   acc_trim_flag_i;
  logic                   pmt_scan_en_o;
  logic [TRIM_TIME_W-1:0] trim_time_pose_o;
  logic [TRIM_TIME_W-1:0] trim_time_nege_o;
  logic                   cfg_pending_o;
  logic                   cfg_applied_o;
  logic [1:0]             state_o;
  logic [CNT_W-1:0]       pulse_cnt_o;
  logic [CNT_W-1:0]       miss_cnt_o;

  modport master (
    output cfg_wr_i, cfg_pose_i, cfg_nege_i,
    output scan_start_i, scan_stop_i,
    output acc_demo_flag_i, acc_trim_flag_i,
    input  pmt_scan_en_o, trim_time_pose_o,
    input  trim_time_nege_o, cfg_pending_o,
    input  cfg_applied_o, state_o,
    input  pulse_cnt_o, miss_cnt_o
  );

  modport slave (
    input  cfg_wr_i, cfg_pose_i, cfg_nege_i,
    input  scan_start_i, scan_stop_i,
    input  acc_demo_flag_i, acc_trim_flag_i,
    output pmt_scan_en_o, trim_time_pose_o,
    output trim_time_nege_o, cfg_pending_o,
    output cfg_applied_o, state_o,
    output pulse_cnt_o, miss_cnt_o
  );

endinterface

// File: rtl/acc_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module acc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/acc_trim_cfg_ctrl.sv
// Scan sequencer and shadowed trim-time scheduler.
// Config only lands while the flag path is quiet.
module acc_trim_cfg_ctrl
  import acc_pkg::*;
#(
  parameter int                     QUIET_CYC     = 4,
  parameter int                     DRAIN_TIMEOUT = 4096,
  parameter logic [TRIM_TIME_W-1:0] DEF_POSE      = 16'd0,
  parameter logic [TRIM_TIME_W-1:0] DEF_NEGE      = 16'd0,
  parameter int                     CNT_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  acc_trim_cfg_ctrl_if.slave bus
);

  localparam int QW = $clog2(QUIET_CYC + 1);
  localparam int DW = $clog2(DRAIN_TIMEOUT);

  state_t                 state_q, state_d;
  logic [QW-1:0]          quiet_q;
  logic [DW-1:0]          drain_q;
  logic                   flag_q, trim_q, seen_q;
  logic [TRIM_TIME_W-1:0] sh_pose_q, sh_nege_q;
  logic [TRIM_TIME_W-1:0] pose_q, nege_q;
  logic                   pending_q, applied_q;
  logic                   scan_en_q;

  logic quiet, idle_in, apply;
  logic flag_rise, flag_fall, trim_rise;
  logic cnt_clr, pulse_inc, miss_inc;

  assign idle_in   = !bus.acc_demo_flag_i && !bus.acc_trim_flag_i;
  assign quiet     = (quiet_q == QW'(QUIET_CYC));
  assign flag_rise = bus.acc_demo_flag_i && !flag_q;
  assign flag_fall = !bus.acc_demo_flag_i && flag_q;
  assign trim_rise = bus.acc_trim_flag_i && !trim_q;

  assign apply = pending_q && !bus.cfg_wr_i &&
                 ((state_q == ST_IDLE) || quiet);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.scan_start_i && !bus.scan_stop_i)
          state_d = ST_ARM;
      end
      ST_ARM: begin
        if (bus.scan_stop_i)
          state_d = ST_IDLE;
        else if (quiet)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.scan_stop_i)
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (idle_in || (drain_q == DW'(DRAIN_TIMEOUT - 1)))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      scan_en_q <= 1'b0;
      quiet_q   <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      scan_en_q <= scan_on(state_d);
      if (!idle_in)
        quiet_q <= '0;
      else if (!quiet)
        quiet_q <= quiet_q + 1'b1;
      if (state_q != ST_DRAIN)
        drain_q <= '0;
      else
        drain_q <= drain_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_pose_q <= DEF_POSE;
      sh_nege_q <= DEF_NEGE;
      pose_q    <= DEF_POSE;
      nege_q    <= DEF_NEGE;
      pending_q <= 1'b0;
      applied_q <= 1'b0;
    end else begin
      applied_q <= apply;
      if (bus.cfg_wr_i) begin
        sh_pose_q <= bus.cfg_pose_i;
        sh_nege_q <= bus.cfg_nege_i;
        pending_q <= 1'b1;
      end else if (apply) begin
        pose_q    <= sh_pose_q;
        nege_q    <= sh_nege_q;
        pending_q <= 1'b0;
      end
    end
  end

  // seen: a trim rise happened since the current flag pulse began
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flag_q <= 1'b0;
      trim_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      flag_q <= bus.acc_demo_flag_i;
      trim_q <= bus.acc_trim_flag_i;
      if (flag_rise)
        seen_q <= trim_rise;
      else if (trim_rise)
        seen_q <= 1'b1;
    end
  end

  assign cnt_clr   = (state_q != ST_ARM) && (state_d == ST_ARM);
  assign pulse_inc = (state_q == ST_RUN) && flag_rise;
  assign miss_inc  = (state_q == ST_RUN) && flag_fall && !seen_q;

  acc_sat_cnt #(.W(CNT_W)) u_pulse_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (pulse_inc),
    .cnt_o (bus.pulse_cnt_o)
  );

  acc_sat_cnt #(.W(CNT_W)) u_miss_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (miss_inc),
    .cnt_o (bus.miss_cnt_o)
  );

  assign bus.pmt_scan_en_o    = scan_en_q;
  assign bus.trim_time_pose_o = pose_q;
  assign bus.trim_time_nege_o = nege_q;
  assign bus.cfg_pending_o    = pending_q;
  assign bus.cfg_applied_o    = applied_q;
  assign bus.state_o          = state_q;

endmodule

// File: tb/tb_acc_trim_cfg_ctrl.sv
// Scenario bench for acc_trim_cfg_ctrl.
// Config writes are scoreboarded and popped on each applied pulse.
module tb_acc_trim_cfg_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    logic [15:0] pose;
    logic [15:0] nege;
  } cfg_t;

  cfg_t exp_q[$];

  acc_trim_cfg_ctrl_if bus ();

  acc_trim_cfg_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [15:0] p, input logic [15:0] n);
    cfg_t e;
    e.pose = p;
    e.nege = n;
    exp_q.push_back(e);
    bus.cfg_wr_i   = 1'b1;
    bus.cfg_pose_i = p;
    bus.cfg_nege_i = n;
    tick();
    bus.cfg_wr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cfg_wr_i        = 1'b0;
    bus.cfg_pose_i      = '0;
    bus.cfg_nege_i      = '0;
    bus.scan_start_i    = 1'b0;
    bus.scan_stop_i     = 1'b0;
    bus.acc_demo_flag_i = 1'b0;
    bus.acc_trim_flag_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.state_o !== 2'd0 || bus.pmt_scan_en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got st=%0d en=%b want st=0 en=0",
               bus.state_o, bus.pmt_scan_en_o);
    end
    checks++;
    if (bus.trim_time_pose_o !== 16'd0 || bus.trim_time_nege_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_times got %0d/%0d want 0/0",
               bus.trim_time_pose_o, bus.trim_time_nege_o);
    end
    checks++;
    if (bus.cfg_pending_o !== 1'b0 || bus.cfg_applied_o !== 1'b0 ||
        bus.pulse_cnt_o !== 16'd0 || bus.miss_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_misc got pend=%b app=%b pc=%0d mc=%0d want 0",
               bus.cfg_pending_o, bus.cfg_applied_o,
               bus.pulse_cnt_o, bus.miss_cnt_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cfg_idle();
    cfg_t e;
    cfg_write(16'd10, 16'd20);
    checks++;
    if (bus.cfg_pending_o !== 1'b1 || bus.trim_time_pose_o !== 16'd0) begin
      errors++;
      $display("FAIL idle_shadow got pend=%b pose=%0d want 1/0",
               bus.cfg_pending_o, bus.trim_time_pose_o);
    end
    tick();
    checks++;
    if (bus.cfg_applied_o !== 1'b1 || bus.cfg_pending_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_apply got app=%b pend=%b want 1/0",
               bus.cfg_applied_o, bus.cfg_pending_o);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (bus.trim_time_pose_o !== e.pose || bus.trim_time_nege_o !== e.nege) begin
        errors++;
        $display("FAIL idle_times got %0d/%0d want %0d/%0d",
                 bus.trim_time_pose_o, bus.trim_time_nege_o, e.pose, e.nege);
      end
    end
    tick();
    checks++;
    if (bus.cfg_applied_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_pulse_width got app=%b want 0", bus.cfg_applied_o);
    end
  endtask

  task automatic test_arm();
    bus.scan_start_i = 1'b1;
    bus.scan_stop_i  = 1'b1;
    tick();
    bus.scan_stop_i = 1'b0;
    checks++;
    if (bus.state_o !== 2'd0) begin
      errors++;
      $display("FAIL start_stop_same got st=%0d want 0", bus.state_o);
    end
    bus.acc_demo_flag_i = 1'b1;
    tick();
    bus.scan_start_i = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.state_o !== 2'd1 || bus.pmt_scan_en_o !== 1'b0) begin
      errors++;
      $display("FAIL arm_hold got st=%0d en=%b want 1/0",
               bus.state_o, bus.pmt_scan_en_o);
    end
    bus.acc_demo_flag_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.state_o !== 2'd1 || bus.pmt_scan_en_o !== 1'b0) begin
        errors++;
        $display("FAIL arm_quiet%0d got st=%0d en=%b want 1/0",
                 i, bus.state_o, bus.pmt_scan_en_o);
      end
    end
    tick();
    checks++;
    if (bus.state_o !== 2'd2 || bus.pmt_scan_en_o !== 1'b1) begin
      errors++;
      $display("FAIL arm_to_run got st=%0d en=%b want 2/1",
               bus.state_o, bus.pmt_scan_en_o);
    end
  endtask

  task automatic test_cfg_run();
    cfg_t e;
    bit   seen;
    bus.acc_demo_flag_i = 1'b1;
    tick();
    cfg_write(16'd30, 16'd20);
    repeat (3) tick();
    checks++;
    if (bus.cfg_pending_o !== 1'b1 || bus.trim_time_pose_o !== 16'd10) begin
      errors++;
      $display("FAIL run_pending got pend=%b pose=%0d want 1/10",
               bus.cfg_pending_o, bus.trim_time_pose_o);
    end
    bus.acc_demo_flag_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.trim_time_pose_o !== 16'd10 || bus.cfg_applied_o !== 1'b0) begin
        errors++;
        $display("FAIL run_early_apply%0d got pose=%0d app=%b want 10/0",
                 i, bus.trim_time_pose_o, bus.cfg_applied_o);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = (bus.cfg_applied_o === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL run_apply_timeout got app=0 want 1");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (bus.trim_time_pose_o !== e.pose || bus.trim_time_nege_o !== e.nege) begin
        errors++;
        $display("FAIL run_times got %0d/%0d want %0d/%0d",
                 bus.trim_time_pose_o, bus.trim_time_nege_o, e.pose, e.nege);
      end
    end
    bus.scan_stop_i = 1'b1;
    tick();
    bus.scan_stop_i = 1'b0;
    tick();
    checks++;
    if (bus.state_o !== 2'd0 || bus.pmt_scan_en_o !== 1'b0) begin
      errors++;
      $display("FAIL quiet_drain got st=%0d en=%b want 0/0",
               bus.state_o, bus.pmt_scan_en_o);
    end
  endtask

  task automatic pulse(input bit with_trim);
    bus.acc_demo_flag_i = 1'b1;
    tick();
    if (with_trim) bus.acc_trim_flag_i = 1'b1;
    tick();
    bus.acc_demo_flag_i = 1'b0;
    tick();
    bus.acc_trim_flag_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_stats();
    bus.scan_start_i = 1'b1;
    tick();
    bus.scan_start_i = 1'b0;
    checks++;
    if (bus.state_o !== 2'd1 || bus.pulse_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL arm_clear1 got st=%0d pc=%0d want 1/0",
               bus.state_o, bus.pulse_cnt_o);
    end
    tick();
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b1);
    checks++;
    if (bus.pulse_cnt_o !== 16'd3 || bus.miss_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL stats_run got pc=%0d mc=%0d want 3/1",
               bus.pulse_cnt_o, bus.miss_cnt_o);
    end
    bus.scan_stop_i = 1'b1;
    tick();
    bus.scan_stop_i = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.state_o !== 2'd0 || bus.pulse_cnt_o !== 16'd3 ||
        bus.miss_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL stats_hold got st=%0d pc=%0d mc=%0d want 0/3/1",
               bus.state_o, bus.pulse_cnt_o, bus.miss_cnt_o);
    end
    bus.scan_start_i = 1'b1;
    tick();
    bus.scan_start_i = 1'b0;
    checks++;
    if (bus.pulse_cnt_o !== 16'd0 || bus.miss_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL arm_clear2 got pc=%0d mc=%0d want 0/0",
               bus.pulse_cnt_o, bus.miss_cnt_o);
    end
    tick();
  endtask

  task automatic test_drain();
    int n;
    bus.acc_trim_flag_i = 1'b1;
    tick();
    bus.scan_stop_i = 1'b1;
    tick();
    bus.scan_stop_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.state_o !== 2'd3 || bus.pmt_scan_en_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_hold got st=%0d en=%b want 3/1",
               bus.state_o, bus.pmt_scan_en_o);
    end
    bus.acc_trim_flag_i = 1'b0;
    tick();
    checks++;
    if (bus.state_o !== 2'd0 || bus.pmt_scan_en_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit got st=%0d en=%b want 0/0",
               bus.state_o, bus.pmt_scan_en_o);
    end
    bus.scan_start_i = 1'b1;
    tick();
    bus.scan_start_i = 1'b0;
    for (int i = 0; i < 10 && bus.state_o !== 2'd2; i++) tick();
    checks++;
    if (bus.state_o !== 2'd2) begin
      errors++;
      $display("FAIL drain_rearm got st=%0d want 2", bus.state_o);
    end
    bus.acc_trim_flag_i = 1'b1;
    tick();
    bus.scan_stop_i = 1'b1;
    tick();
    bus.scan_stop_i = 1'b0;
    n = 0;
    while (bus.state_o !== 2'd0 && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (n != 4096 || bus.pmt_scan_en_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout got cycles=%0d en=%b want 4096/0",
               n, bus.pmt_scan_en_o);
    end
    bus.acc_trim_flag_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.scan_start_i = 1'b1;
    tick();
    bus.scan_start_i = 1'b0;
    for (int i = 0; i < 10 && bus.state_o !== 2'd2; i++) tick();
    bus.acc_demo_flag_i = 1'b1;
    tick();
    cfg_write(16'd55, 16'd66);
    checks++;
    if (bus.state_o !== 2'd2 || bus.cfg_pending_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got st=%0d pend=%b want 2/1",
               bus.state_o, bus.cfg_pending_o);
    end
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if (bus.state_o !== 2'd0 || bus.pmt_scan_en_o !== 1'b0 ||
        bus.cfg_pending_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got st=%0d en=%b pend=%b want 0/0/0",
               bus.state_o, bus.pmt_scan_en_o, bus.cfg_pending_o);
    end
    checks++;
    if (bus.trim_time_pose_o !== 16'd0 || bus.trim_time_nege_o !== 16'd0) begin
      errors++;
      $display("FAIL mid_times got %0d/%0d want 0/0",
               bus.trim_time_pose_o, bus.trim_time_nege_o);
    end
    bus.acc_demo_flag_i = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.cfg_applied_o !== 1'b0 || bus.trim_time_pose_o !== 16'd0) begin
      errors++;
      $display("FAIL mid_discard got app=%b pose=%0d want 0/0",
               bus.cfg_applied_o, bus.trim_time_pose_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_cfg_idle();
    test_arm();
    test_cfg_run();
    test_stats();
    test_drain();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
